// File: rtl/piso_pkg.sv
// Shared constants and helpers for the parallel-in serial-out block (piso).
package piso_pkg;

  localparam int PISO_DEFAULT_WIDTH = 4;

  // Counter must be able to hold WIDTH itself when the parity bit is appended.
  function automatic int piso_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Even parity of a data word; zero-extended upper bits do not change the result.
  function automatic logic piso_even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter for piso: counts 0..tc and wraps, flagging the terminal count.
module piso_bit_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] tc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_r;
  logic             wrap_s;

  // Terminal-count decode.
  always_comb begin
    wrap_s = (cnt_r == tc);
  end

  // Count register: cleared by reset and at terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (wrap_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt  = cnt_r;
  assign wrap = wrap_s;

endmodule

// File: rtl/piso.sv
// Parallel-in serial-out shifter, MSB first, back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic             q
);

  localparam int CNT_W = piso_cnt_width(WIDTH);
`ifdef PISO_PARITY_EN
  localparam int LAST_BIT = WIDTH;
`else
  localparam int LAST_BIT = WIDTH - 1;
`endif
  localparam logic [CNT_W-1:0] TC = CNT_W'(LAST_BIT);

  logic [WIDTH-1:0] temp_r;
  logic [WIDTH-1:0] temp_nxt_s;
  logic             q_r;
  logic             q_nxt_s;
  logic [CNT_W-1:0] cnt_s;
  logic             wrap_s;
  logic             reload_s;

  piso_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .tc   (TC),
    .cnt  (cnt_s),
    .wrap (wrap_s)
  );

  // Reload only when the wrap flag and the count value agree on the last bit.
  always_comb begin
    reload_s = wrap_s && (cnt_s == TC);
  end

`ifdef PISO_PARITY_EN
  logic par_r;

  // Parity of the loaded word, captured alongside the shift register.
  always_ff @(posedge clk) begin
    if (rst || reload_s) begin
      par_r <= piso_even_parity(32'(d));
    end else begin
      par_r <= par_r;
    end
  end
`endif

  // Next shift-register contents and next serial bit.
  always_comb begin
    temp_nxt_s = temp_r << 1;
    q_nxt_s    = temp_r[WIDTH-1];
    if (rst) begin
      temp_nxt_s = d;
      q_nxt_s    = 1'b0;
    end else if (reload_s) begin
      temp_nxt_s = d;
`ifdef PISO_PARITY_EN
      q_nxt_s    = par_r;
`else
      q_nxt_s    = temp_r[WIDTH-1];
`endif
    end else begin
      temp_nxt_s = temp_r << 1;
      q_nxt_s    = temp_r[WIDTH-1];
    end
  end

  // Shift register and registered serial output.
  always_ff @(posedge clk) begin
    temp_r <= temp_nxt_s;
    q_r    <= q_nxt_s;
  end

  assign q = q_r;

endmodule

// File: tb/tb_piso.sv
// Directed self-checking bench for piso (WIDTH=4 and WIDTH=8 instances).
// Expected sequences switch with PISO_PARITY_EN.
module tb_piso;

  logic       clk;
  logic       rst;
  logic [3:0] d;
  logic       q;
  logic       rst8;
  logic [7:0] d8;
  logic       q8;

  int compared;
  int mismatched;

  piso dut4 (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q)
  );

  piso #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst8),
    .d   (d8),
    .q   (q8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge, then compare n bits of exp (MSB of the n-bit field first).
  task automatic check_seq(input string tag, input logic [63:0] exp, input int n,
                           input bit use8);
    logic obs;
    logic e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      obs = use8 ? q8 : q;
      e   = exp[n-1-i];
      compared++;
      assert (obs === e) else begin
        mismatched++;
        $error("FAIL %s bit %0d: observed %b expected %b", tag, i, obs, e);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst  = 1'b1;
    d    = 4'b0000;
    rst8 = 1'b1;
    d8   = 8'h00;
    @(negedge clk);

    // Basic serialisation of 1101.
    d   = 4'b1101;
    rst = 1'b1;
    check_seq("reset_q", 64'd0, 1, 1'b0);
    rst = 1'b0;
`ifdef PISO_PARITY_EN
    check_seq("par_1101", 64'b1101111011, 10, 1'b0);
`else
    check_seq("basic_1101", 64'b11011101, 8, 1'b0);
`endif

    // d changes mid-frame must only affect the following frame.
    rst = 1'b1;
    check_seq("reset_q2", 64'd0, 1, 1'b0);
    rst = 1'b0;
    check_seq("midchg_head", 64'b11, 2, 1'b0);
    d = 4'b0010;
`ifdef PISO_PARITY_EN
    check_seq("midchg_tail", 64'b01100101, 8, 1'b0);
`else
    check_seq("midchg_tail", 64'b010010, 6, 1'b0);
`endif

    // Reset mid-frame aborts and reloads from d at reset.
    d   = 4'b1011;
    rst = 1'b1;
    check_seq("reset_q3", 64'd0, 1, 1'b0);
    rst = 1'b0;
    check_seq("abort_head", 64'b10, 2, 1'b0);
    d   = 4'b0110;
    rst = 1'b1;
    check_seq("abort_rst", 64'b00, 2, 1'b0);
    rst = 1'b0;
`ifdef PISO_PARITY_EN
    check_seq("abort_0110", 64'b01100, 5, 1'b0);
`else
    check_seq("abort_0110", 64'b0110, 4, 1'b0);
`endif

    // Long reset with d changing each edge: q stays low, last d wins.
    for (int i = 0; i < 10; i++) begin
      d   = (i == 9) ? 4'b1001 : 4'(i * 7 + 2);
      rst = 1'b1;
      check_seq("long_rst", 64'd0, 1, 1'b0);
    end
    rst = 1'b0;
    d   = 4'b0000;
`ifdef PISO_PARITY_EN
    check_seq("after_long_rst", 64'b10010, 5, 1'b0);
`else
    check_seq("after_long_rst", 64'b1001, 4, 1'b0);
`endif

    // WIDTH=8 instance with A5, two full periods.
    d8   = 8'hA5;
    rst8 = 1'b1;
    check_seq("w8_reset", 64'd0, 1, 1'b1);
    rst8 = 1'b0;
`ifdef PISO_PARITY_EN
    check_seq("w8_a5", 64'b101001010101001010, 18, 1'b1);
`else
    check_seq("w8_a5", 64'hA5A5, 16, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
